// File: rtl/regfile_ctl_pkg.sv
// Shared types and helpers for the register-file port controllers.
// No logic; constants and functions only.
// Not applicable (no handshake).
package regfile_ctl_pkg;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Width of a requester index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    localparam int NREQ_DEF = 4;
    localparam int ID_W     = id_width(NREQ_DEF);

endpackage

// File: rtl/regfile_wr_sched_if.sv
// Bundle between write requesters and the register-file write scheduler.
// Pure wiring, no latency.
// req_valid/req_ready per requester; init_start is sampled only in run mode.
interface regfile_wr_sched_if
    import regfile_ctl_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    localparam int GID_W = id_width(NREQ);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic                   init_start;
    logic                   init_busy;
    logic [ADDR_W-1:0]      rf_addr_in;
    logic [DATA_W-1:0]      rf_d_in;
    logic                   rf_we;
    logic [GID_W-1:0]       grant_id;
    logic                   err_oob;
    logic                   err_clr;

    modport master (
        output req_valid, req_addr, req_data, init_start, err_clr,
        input  req_ready, init_busy, rf_addr_in, rf_d_in, rf_we, grant_id, err_oob
    );

    modport slave (
        input  req_valid, req_addr, req_data, init_start, err_clr,
        output req_ready, init_busy, rf_addr_in, rf_d_in, rf_we, grant_id, err_oob
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from a rotating pointer.
// Grant is combinational; pointer updates on the edge after an advance.
// Grants only asserted requests; pointer holds while advance is low.
module rr_arbiter
    import regfile_ctl_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IW   = id_width(NREQ)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx
);

    logic [IW-1:0] ptr_q;
    logic          found;
    int            idx;

    // First asserted request at or above the pointer, wrapping modulo NREQ.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IW'(idx);
            end
        end
    end

    // Pointer moves just past the winner of a completed transfer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q <= '0;
        end else if (advance && found) begin
            ptr_q <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wr_sched.sv
// Owns the register-file write port: clear sweep after reset/init_start, then round-robin writes.
// One cycle from accepted request (or sweep step) to rf_* outputs.
// req_ready is held low during a sweep and in the init_start cycle; accepted out-of-range writes are dropped.
module regfile_wr_sched
    import regfile_ctl_pkg::*;
#(
    parameter int              NREQ     = 4,
    parameter int              ADDR_W   = 5,
    parameter int              DATA_W   = 32,
    parameter int              LO       = 0,
    parameter int              HI       = 31,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input logic               CLK,
    input logic               RST,
    regfile_wr_sched_if.slave bus
);

    localparam int IW = id_width(NREQ);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic              busy_q;
    logic [NREQ-1:0]   arb_req;
    logic [NREQ-1:0]   gnt;
    logic [IW-1:0]     gnt_idx;
    logic              xfer;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              lo_ok, hi_ok, in_range;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              we_q;
    logic [IW-1:0]     gid_q;
    logic              err_q;

    // Requests only reach the arbiter in run mode and never alongside init_start.
    assign arb_req = (state_q == S_RUN && !bus.init_start) ? bus.req_valid : '0;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .CLK     (CLK),
        .RST     (RST),
        .req     (arb_req),
        .advance (xfer),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign bus.req_ready = gnt;
    assign xfer          = |gnt;
    assign w_addr        = bus.req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    assign w_data        = bus.req_data[int'(gnt_idx)*DATA_W +: DATA_W];

    // Bound checks collapse to constants when a bound covers the whole address space.
    if (LO == 0) begin : gen_lo_free
        assign lo_ok = 1'b1;
    end else begin : gen_lo_cmp
        assign lo_ok = (w_addr >= ADDR_W'(LO));
    end
    if (HI >= (2**ADDR_W) - 1) begin : gen_hi_free
        assign hi_ok = 1'b1;
    end else begin : gen_hi_cmp
        assign hi_ok = (w_addr <= ADDR_W'(HI));
    end
    assign in_range = lo_ok && hi_ok;

    // Next state: leave the sweep after the HI step, re-enter on init_start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:  if (cnt_q == ADDR_W'(HI)) state_d = S_RUN;
            S_RUN:   if (bus.init_start)       state_d = S_INIT;
            default: state_d = S_INIT;
        endcase
    end

    // State register, sweep counter and busy flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_INIT;
            cnt_q   <= ADDR_W'(LO);
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == S_INIT);
            if (state_q == S_INIT) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (bus.init_start) begin
                cnt_q <= ADDR_W'(LO);
            end
        end
    end

    // Output stage: sweep write, granted write, or idle with address/data held.
    always_ff @(posedge CLK) begin
        if (RST) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            gid_q  <= '0;
        end else if (state_q == S_INIT) begin
            we_q   <= 1'b1;
            addr_q <= cnt_q;
            data_q <= INIT_VAL;
        end else if (xfer) begin
            we_q   <= in_range;
            addr_q <= w_addr;
            data_q <= w_data;
            gid_q  <= gnt_idx;
        end else begin
            we_q   <= 1'b0;
        end
    end

    // Sticky out-of-range flag; a new error beats a clear in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            err_q <= 1'b0;
        end else if (xfer && !in_range) begin
            err_q <= 1'b1;
        end else if (bus.err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign bus.rf_we      = we_q;
    assign bus.rf_addr_in = addr_q;
    assign bus.rf_d_in    = data_q;
    assign bus.grant_id   = gid_q;
    assign bus.err_oob    = err_q;
    assign bus.init_busy  = busy_q;

endmodule
